counter_checker: RTL and testbench
==================================

COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 The block SHALL expose parameter LOCK_LEN, default 4: the number of consecutive correct increments required to lock (legal range 1..15).
REQ-002 Port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port q_in, input, 4 bits: count value from the upstream 4-bit up-counter.
REQ-005 Port q_valid, input, 1 bit: q_in is sampled only on edges where q_valid=1.
REQ-006 Port locked, output, 1 bit: high while the FSM is in TRACK.
REQ-007 Port err_pulse, output, 1 bit: one-cycle pulse per detected sequence error.
REQ-008 Port err_cnt, output, 8 bits: saturating count of sequence errors.
REQ-009 Port wrap_cnt, output, 8 bits: saturating count of 15->0 wraps seen while locked.
REQ-010 Port last_bad, output, 4 bits: q_in value of the most recent erroneous sample.

Function
REQ-011 Expected value SHALL be prev+1 modulo 16, so 15 followed by 0 is correct.
REQ-012 FSM states SHALL be IDLE, SYNC, TRACK and ERROR; all outputs are registered and update one cycle after the sampling edge.
REQ-013 IDLE, valid sample: store prev=q_in, run=0, go to SYNC.
REQ-014 SYNC, valid correct sample: run increments; when run reaches LOCK_LEN, go to TRACK.
REQ-015 SYNC, valid incorrect sample: run=0 and stay in SYNC, with no error count and no err_pulse.
REQ-016 TRACK, valid correct sample: stay in TRACK; wrap_cnt increments when prev=15 and q_in=0.
REQ-017 TRACK, valid incorrect sample (including repeated value q_in==prev): go to ERROR; err_pulse=1 for exactly that cycle; err_cnt increments; last_bad=q_in; locked drops.
REQ-018 ERROR SHALL last exactly one cycle, then go to SYNC with run=0.
REQ-019 A valid sample in the ERROR cycle SHALL be stored as prev and not checked.
REQ-020 prev SHALL update on every valid sample in every state.
REQ-021 q_valid=0 SHALL hold state, prev, run and all counters unchanged; an error is not inferred from gaps.
REQ-022 err_cnt and wrap_cnt SHALL saturate at 255 and never wrap.
REQ-023 locked SHALL equal (state==TRACK), registered.

Reset
REQ-024 Asserting reset low SHALL immediately and asynchronously force: state=IDLE, prev=0, run=0, locked=0, err_pulse=0, err_cnt=0, wrap_cnt=0, last_bad=0.
REQ-025 Reset asserted mid-operation (any state) SHALL abandon the current sample.
REQ-026 After reset release, the first valid sample SHALL be treated as in IDLE.

Configuration
REQ-027 With macro COUNTER_CHECKER_STICKY_EN defined, the block SHALL add input err_clr (1 bit) and output err_sticky (1 bit).
REQ-028 err_sticky SHALL set on any err_pulse and clear only on err_clr=1 or reset; set wins if err_clr coincides with a new error.
REQ-029 With COUNTER_CHECKER_STICKY_EN undefined, neither port exists and the remaining behaviour is identical.

Verification
REQ-030 Lock and wrap: reset low 10 ns then high; q_valid=1; q_in=0,1,2,...,15,0,1 -> locked=1 one cycle after the 5th sample (LOCK_LEN=4); wrap_cnt=1 after the 15->0 sample; err_cnt=0.
REQ-031 Single error: after lock, apply sequence 5,6,9,10 -> err_pulse=1 for one cycle after the sample 9; err_cnt=1; last_bad=9; locked=0; relock after four further correct increments.
REQ-032 Gaps: locked; q_in=3, then q_valid=0 for 3 cycles with q_in=12, then q_in=4 valid -> no error, locked stays 1.
REQ-033 Saturation: force 300 errors by alternating lock/bad sequences -> err_cnt holds at 255; repeat for 300 wraps -> wrap_cnt holds at 255.
REQ-034 Reset mid-TRACK: assert reset low between clock edges while err_cnt=2 -> all outputs 0 immediately, without waiting for a clock edge.
REQ-035 Sticky (COUNTER_CHECKER_STICKY_EN defined): error -> err_sticky=1; err_clr pulse -> 0; err_clr coincident with a new error -> err_sticky=1.

Source files
------------

// File: rtl/counter_checker.sv
// Sequence checker for a 4-bit up-counter: locks after LOCK_LEN correct increments, then counts errors and wraps.
// Optional sticky error flag (err_clr / err_sticky) is built when COUNTER_CHECKER_STICKY_EN is defined.
module counter_checker #(
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q_in,
  input  logic       q_valid,
`ifdef COUNTER_CHECKER_STICKY_EN
  input  logic       err_clr,
  output logic       err_sticky,
`endif
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic [7:0] wrap_cnt,
  output logic [3:0] last_bad
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_C = LOCK_LEN[3:0];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_prev;
  logic [3:0] w_prev_nxt;
  logic [3:0] r_run;
  logic [3:0] w_run_nxt;
  logic [3:0] w_expect;
  logic [3:0] w_run_inc;
  logic       w_correct;
  logic       w_err_det;
  logic       w_wrap_det;

  logic       r_locked;
  logic       r_err_pulse;
  logic [7:0] r_err_cnt;
  logic [7:0] r_wrap_cnt;
  logic [3:0] r_last_bad;

  assign w_expect  = r_prev + 4'd1;
  assign w_run_inc = r_run + 4'd1;
  assign w_correct = (q_in == w_expect);

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_run_nxt   = r_run;
    w_err_det   = 1'b0;
    w_wrap_det  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (q_valid) begin
          w_prev_nxt  = q_in;
          w_run_nxt   = 4'd0;
          w_state_nxt = S_SYNC;
        end
      end
      S_SYNC: begin
        if (q_valid) begin
          w_prev_nxt = q_in;
          if (w_correct) begin
            if (w_run_inc == LOCK_C) begin
              w_run_nxt   = 4'd0;
              w_state_nxt = S_TRACK;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            w_run_nxt = 4'd0;
          end
        end
      end
      S_TRACK: begin
        if (q_valid) begin
          w_prev_nxt = q_in;
          if (w_correct) begin
            w_wrap_det = (r_prev == 4'hF) && (q_in == 4'h0);
          end else begin
            w_err_det   = 1'b1;
            w_state_nxt = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        // Sample arriving during the error cycle only re-seeds prev.
        if (q_valid) w_prev_nxt = q_in;
        w_run_nxt   = 4'd0;
        w_state_nxt = S_SYNC;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_run_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_prev      <= 4'd0;
      r_run       <= 4'd0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_wrap_cnt  <= 8'd0;
      r_last_bad  <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_run       <= w_run_nxt;
      r_locked    <= (w_state_nxt == S_TRACK);
      r_err_pulse <= w_err_det;
      if (w_err_det) begin
        r_err_cnt  <= sat_inc8(r_err_cnt);
        r_last_bad <= q_in;
      end
      if (w_wrap_det) r_wrap_cnt <= sat_inc8(r_wrap_cnt);
    end
  end

`ifdef COUNTER_CHECKER_STICKY_EN
  logic r_err_sticky;

  // A new error takes priority over a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_sticky <= 1'b0;
    end else if (w_err_det) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky = r_err_sticky;
`endif

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign wrap_cnt  = r_wrap_cnt;
  assign last_bad  = r_last_bad;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker (LOCK_LEN=4); sticky checks build when COUNTER_CHECKER_STICKY_EN is defined.
module tb_counter_checker;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       q_valid;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;
  logic [3:0] last_bad;
`ifdef COUNTER_CHECKER_STICKY_EN
  logic       err_clr;
  logic       err_sticky;
`endif

  int n_tot;
  int n_bad;
  logic [3:0] p;

  counter_checker #(.LOCK_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .q_valid   (q_valid),
`ifdef COUNTER_CHECKER_STICKY_EN
    .err_clr   (err_clr),
    .err_sticky(err_sticky),
`endif
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .wrap_cnt  (wrap_cnt),
    .last_bad  (last_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one sample at the falling edge, return 1 ns after the capturing rising edge.
  task automatic step(input logic v, input logic [3:0] q);
    @(negedge clk);
    q_valid = v;
    q_in    = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tot   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    q_valid = 1'b0;
    q_in    = 4'd0;
`ifdef COUNTER_CHECKER_STICKY_EN
    err_clr = 1'b0;
`endif
    #2;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_wrapcnt", 32'(wrap_cnt), 32'd0);
    chk("rst_lastbad", 32'(last_bad), 32'd0);
`ifdef COUNTER_CHECKER_STICKY_EN
    chk("rst_sticky", 32'(err_sticky), 32'd0);
`endif
    #8 reset = 1'b1;

    // Lock and wrap: 0..15,0,1
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 4'(i % 16));
      if (i == 3)  chk("lock_before", 32'(locked), 32'd0);
      if (i == 4)  chk("lock_after5", 32'(locked), 32'd1);
      if (i == 15) chk("wrap_pre", 32'(wrap_cnt), 32'd0);
      if (i == 16) chk("wrap_post", 32'(wrap_cnt), 32'd1);
    end
    chk("lock_errcnt", 32'(err_cnt), 32'd0);

    // Single error: ...,5,6,9,10 then relock on 11..14
    for (int v = 2; v <= 6; v++) step(1'b1, 4'(v));
    step(1'b1, 4'd9);
    chk("err_pulse", 32'(err_pulse), 32'd1);
    chk("err_cnt1", 32'(err_cnt), 32'd1);
    chk("err_lastbad", 32'(last_bad), 32'd9);
    chk("err_unlock", 32'(locked), 32'd0);
    step(1'b1, 4'd10);
    chk("err_pulse_1cyc", 32'(err_pulse), 32'd0);
    chk("err_state_unlock", 32'(locked), 32'd0);
    step(1'b1, 4'd11);
    step(1'b1, 4'd12);
    step(1'b1, 4'd13);
    chk("relock_early", 32'(locked), 32'd0);
    step(1'b1, 4'd14);
    chk("relock", 32'(locked), 32'd1);

    // Gaps: 15,0,1,2,3, three invalid cycles with q_in=12, then 4
    step(1'b1, 4'd15);
    for (int v = 0; v <= 3; v++) step(1'b1, 4'(v));
    chk("gap_wrap2", 32'(wrap_cnt), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd12);
    chk("gap_hold_lock", 32'(locked), 32'd1);
    chk("gap_no_pulse", 32'(err_pulse), 32'd0);
    step(1'b1, 4'd4);
    chk("gap_lock", 32'(locked), 32'd1);
    chk("gap_errcnt", 32'(err_cnt), 32'd1);

    // Repeated value in TRACK is an error
    step(1'b1, 4'd4);
    chk("rep_pulse", 32'(err_pulse), 32'd1);
    chk("rep_errcnt", 32'(err_cnt), 32'd2);
    chk("rep_lastbad", 32'(last_bad), 32'd4);
    for (int v = 5; v <= 9; v++) step(1'b1, 4'(v));
    chk("rep_relock", 32'(locked), 32'd1);

    // Asynchronous reset mid-TRACK with err_cnt=2
    #3 reset = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_errcnt", 32'(err_cnt), 32'd0);
    chk("arst_wrapcnt", 32'(wrap_cnt), 32'd0);
    chk("arst_lastbad", 32'(last_bad), 32'd0);
    chk("arst_pulse", 32'(err_pulse), 32'd0);
    #2 reset = 1'b1;

    // After reset: 7 seeds, 8 ok, 3 bad in SYNC (silent), then 4..7 lock
    step(1'b1, 4'd7);
    step(1'b1, 4'd8);
    step(1'b1, 4'd3);
    chk("sync_bad_pulse", 32'(err_pulse), 32'd0);
    chk("sync_bad_cnt", 32'(err_cnt), 32'd0);
    step(1'b1, 4'd4);
    step(1'b1, 4'd5);
    step(1'b1, 4'd6);
    chk("sync_run_reset", 32'(locked), 32'd0);
    step(1'b1, 4'd7);
    chk("sync_relock", 32'(locked), 32'd1);

    // Error saturation: 300 x (bad, reseed, 4 correct)
    p = 4'd7;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, p + 4'd2);
      step(1'b1, p + 4'd3);
      step(1'b1, p + 4'd4);
      step(1'b1, p + 4'd5);
      step(1'b1, p + 4'd6);
      step(1'b1, p + 4'd7);
      p = p + 4'd7;
      if (i == 99) chk("sat_err_100", 32'(err_cnt), 32'd100);
    end
    chk("sat_err_255", 32'(err_cnt), 32'd255);
    chk("sat_err_nowrap", 32'(wrap_cnt), 32'd0);
    chk("sat_err_locked", 32'(locked), 32'd1);

    // Wrap saturation: 4800 correct increments in TRACK = 300 wraps
    for (int i = 0; i < 4800; i++) begin
      p = p + 4'd1;
      step(1'b1, p);
    end
    chk("sat_wrap_255", 32'(wrap_cnt), 32'd255);
    chk("sat_wrap_err", 32'(err_cnt), 32'd255);
    chk("sat_wrap_locked", 32'(locked), 32'd1);

`ifdef COUNTER_CHECKER_STICKY_EN
    step(1'b1, p + 4'd2);
    chk("stk_set", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    step(1'b0, 4'd0);
    err_clr = 1'b0;
    chk("stk_clr", 32'(err_sticky), 32'd0);
    p = p + 4'd2;
    for (int i = 0; i < 4; i++) begin
      p = p + 4'd1;
      step(1'b1, p);
    end
    chk("stk_relock", 32'(locked), 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    q_valid = 1'b1;
    q_in    = p;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("stk_coincide", 32'(err_sticky), 32'd1);
    chk("stk_coincide_pulse", 32'(err_pulse), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
